// File: rtl/ldr_pkg.sv
// Shared types and constants for the LDR lamp controller.
package ldr_pkg;

  localparam int unsigned LDR_W = 8;

  typedef enum logic [1:0] {
    DAY       = 2'd0,
    DUSK_PEND = 2'd1,
    NIGHT     = 2'd2,
    DAWN_PEND = 2'd3
  } lamp_state_t;

  // Lamp is lit in the night state and while a dawn switch is still pending.
  function automatic logic is_lit(input lamp_state_t s);
    return (s == NIGHT) || (s == DAWN_PEND);
  endfunction

endpackage

// File: rtl/ldr_avg.sv
// Window averager: sums 2^AVG_LOG2 accepted readings and publishes the
// truncated mean with a one-cycle valid pulse.
module ldr_avg
  import ldr_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [LDR_W-1:0] ldr_data,
  input  logic             ldr_valid,
  output logic [LDR_W-1:0] avg_level,
  output logic             avg_valid
);

  localparam int unsigned ACC_W = LDR_W + AVG_LOG2;
  localparam logic [4:0]  LAST  = 5'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;
  logic [4:0]       cnt_q;

  // Sum including the current reading; the top LDR_W bits are sum >> AVG_LOG2.
  assign sum = acc_q + ACC_W'(ldr_data);

  // Accumulate accepted readings; close the window on the last sample, drop it when disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_level <= '0;
      avg_valid <= 1'b0;
    end else if (!enable) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_valid <= 1'b0;
    end else if (ldr_valid) begin
      if (cnt_q == LAST) begin
        avg_level <= sum[ACC_W-1 -: LDR_W];
        avg_valid <= 1'b1;
        acc_q     <= '0;
        cnt_q     <= '0;
      end else begin
        acc_q     <= sum;
        cnt_q     <= cnt_q + 5'd1;
        avg_valid <= 1'b0;
      end
    end else begin
      avg_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/ldr_lamp_ctrl.sv
// Day/night lamp controller: paces sample requests, averages readings and
// switches the lamp through a hysteresis FSM.
module ldr_lamp_ctrl
  import ldr_pkg::*;
#(
  parameter int unsigned DARK_TH    = 100,
  parameter int unsigned LIGHT_TH   = 200,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned HOLD_WIN   = 3,
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [LDR_W-1:0] ldr_data,
  input  logic             ldr_valid,
  output logic             sample_req,
  output logic [LDR_W-1:0] avg_level,
  output logic             avg_valid,
  output logic             lamp_on,
  output logic [1:0]       state
);

  localparam int unsigned      DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [LDR_W-1:0] DARK_B   = LDR_W'(DARK_TH);
  localparam logic [LDR_W-1:0] LIGHT_B  = LDR_W'(LIGHT_TH);
  localparam logic [3:0]       HOLD_B   = 4'(HOLD_WIN);

  logic [DIV_W-1:0] div_q;
  lamp_state_t      state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic             dark, light;

  ldr_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ldr_data  (ldr_data),
    .ldr_valid (ldr_valid),
    .avg_level (avg_level),
    .avg_valid (avg_valid)
  );

  // Sample-request divider: pulse on the last count, held at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      sample_req <= 1'b0;
    end else if (!enable) begin
      div_q      <= '0;
      sample_req <= 1'b0;
    end else if (div_q == DIV_LAST) begin
      div_q      <= '0;
      sample_req <= 1'b1;
    end else begin
      div_q      <= div_q + 1'b1;
      sample_req <= 1'b0;
    end
  end

  // FSM state, hold count and lamp register; lamp decodes the next state so it moves with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DAY;
      hold_q  <= '0;
      lamp_on <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      lamp_on <= is_lit(state_d);
    end
  end

  assign dark  = (avg_level < DARK_B);
  assign light = (avg_level > LIGHT_B);

  // Hysteresis transitions, evaluated only when a new average arrives.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (avg_valid) begin
      unique case (state_q)
        DAY: begin
          if (dark) begin
            if (HOLD_WIN == 1) begin
              state_d = NIGHT;
              hold_d  = '0;
            end else begin
              state_d = DUSK_PEND;
              hold_d  = 4'd1;
            end
          end
        end
        DUSK_PEND: begin
          if (dark) begin
            if (hold_q + 4'd1 == HOLD_B) begin
              state_d = NIGHT;
              hold_d  = '0;
            end else begin
              hold_d  = hold_q + 4'd1;
            end
          end else begin
            state_d = DAY;
            hold_d  = '0;
          end
        end
        NIGHT: begin
          if (light) begin
            if (HOLD_WIN == 1) begin
              state_d = DAY;
              hold_d  = '0;
            end else begin
              state_d = DAWN_PEND;
              hold_d  = 4'd1;
            end
          end
        end
        DAWN_PEND: begin
          if (light) begin
            if (hold_q + 4'd1 == HOLD_B) begin
              state_d = DAY;
              hold_d  = '0;
            end else begin
              hold_d  = hold_q + 4'd1;
            end
          end else begin
            state_d = NIGHT;
            hold_d  = '0;
          end
        end
        default: begin
          state_d = DAY;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule
